// File: rtl/ring_osc_cal_pkg.sv
// Shared types and constants for the ring-oscillator calibration controller.
package ring_osc_cal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } cal_state_t;

  localparam logic [2:0] DIV4_SEL = 3'b011;
  localparam logic [2:0] DIV5_SEL = 3'b100;
  localparam logic [2:0] DIV6_SEL = 3'b101;
  localparam logic [2:0] DIV7_SEL = 3'b110;
  localparam logic [2:0] DIV8_SEL = 3'b111;
  localparam logic [2:0] SEL_SAFE = 3'b111;

  localparam int DEF_DIV4_THR = 32;
  localparam int DEF_DIV5_THR = 395;
  localparam int DEF_DIV6_THR = 494;
  localparam int DEF_DIV7_THR = 595;
  localparam int DEF_DIV8_THR = 693;

endpackage

// File: rtl/ring_osc_ref_sync.sv
// Two-flop synchronizer for the 32 kHz reference plus a rising-edge detector.
module ring_osc_ref_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ref_i,
  output logic ref_rise_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ref_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign ref_rise_o = r_sync2 & ~r_sync3;

endmodule

// File: rtl/ring_osc_cal_ctrl.sv
// Ring-oscillator calibration controller: counts clk cycles over N reference periods.
// Optional RING_OSC_CAL_HYST_EN: div_sel_o changes only after two agreeing windows.
module ring_osc_cal_ctrl
  import ring_osc_cal_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 4,
  parameter int DIV4_THR = DEF_DIV4_THR,
  parameter int DIV5_THR = DEF_DIV5_THR,
  parameter int DIV6_THR = DEF_DIV6_THR,
  parameter int DIV7_THR = DEF_DIV7_THR,
  parameter int DIV8_THR = DEF_DIV8_THR
) (
  input  logic             clk_ringosc_i,
  input  logic             reset_i,
  input  logic             clk_32khz_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIN_W-1:0] win_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cal_val_o,
  output logic             ovf_o,
  output logic [2:0]       div_sel_o
);

  localparam logic [CNT_W-1:0] THR4 = CNT_W'(DIV4_THR);
  localparam logic [CNT_W-1:0] THR5 = CNT_W'(DIV5_THR);
  localparam logic [CNT_W-1:0] THR6 = CNT_W'(DIV6_THR);
  localparam logic [CNT_W-1:0] THR7 = CNT_W'(DIV7_THR);
  localparam logic [CNT_W-1:0] THR8 = CNT_W'(DIV8_THR);

  // A count below DIV4 means a dead reference or stopped oscillator: fall back to the slowest divider.
  function automatic logic [2:0] sel_of(input logic [CNT_W-1:0] v, input logic ovf);
    if (ovf)            return SEL_SAFE;
    else if (v >= THR8) return DIV8_SEL;
    else if (v >= THR7) return DIV7_SEL;
    else if (v >= THR6) return DIV6_SEL;
    else if (v >= THR5) return DIV5_SEL;
    else if (v >= THR4) return DIV4_SEL;
    else                return SEL_SAFE;
  endfunction

  cal_state_t       r_state;
  cal_state_t       w_state_nxt;
  logic             w_ref_rise;
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_per;
  logic             r_mode_q;
  logic [CNT_W-1:0] r_cal_val;
  logic             r_ovf;
  logic [2:0]       r_div_sel;
  logic             r_done;

  logic             w_open;
  logic             w_win_end;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_meas;
  logic [2:0]       w_new_sel;
  logic [WIN_W-1:0] w_per_load;
  logic             w_sel_upd;

  ring_osc_ref_sync u_ref_sync (
    .clk_i      (clk_ringosc_i),
    .rst_i      (reset_i),
    .ref_i      (clk_32khz_i),
    .ref_rise_o (w_ref_rise)
  );

  assign w_open     = enable_i & (r_state == ST_ARM) & w_ref_rise;
  assign w_win_end  = enable_i & (r_state == ST_COUNT) & w_ref_rise & (r_per == WIN_W'(1));
  assign w_cnt_sat  = &r_cnt;
  assign w_meas     = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign w_new_sel  = sel_of(w_meas, w_cnt_sat);
  assign w_per_load = (win_len_i == '0) ? WIN_W'(1) : win_len_i;

`ifdef RING_OSC_CAL_HYST_EN
  logic [2:0] r_pend_sel;

  always_ff @(posedge clk_ringosc_i or posedge reset_i) begin
    if (reset_i)        r_pend_sel <= SEL_SAFE;
    else if (w_win_end) r_pend_sel <= w_new_sel;
  end

  assign w_sel_upd = (w_new_sel == r_pend_sel);
`else
  assign w_sel_upd = 1'b1;
`endif

  always_ff @(posedge clk_ringosc_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start_i | mode_i) w_state_nxt = ST_ARM;
        ST_ARM:   if (w_ref_rise)       w_state_nxt = ST_COUNT;
        ST_COUNT: if (w_win_end && !r_mode_q) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ringosc_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt     <= '0;
      r_per     <= '0;
      r_mode_q  <= 1'b0;
      r_cal_val <= '0;
      r_ovf     <= 1'b0;
      r_div_sel <= SEL_SAFE;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!enable_i) begin
        r_cnt <= '0;
        r_per <= '0;
      end else if (w_open) begin
        r_cnt    <= '0;
        r_per    <= w_per_load;
        r_mode_q <= mode_i;
      end else if (r_state == ST_COUNT) begin
        if (w_win_end) begin
          // Closing edge doubles as the opening edge of the next continuous window.
          r_cnt     <= '0;
          r_cal_val <= w_meas;
          r_ovf     <= w_cnt_sat;
          r_done    <= 1'b1;
          if (w_sel_upd) r_div_sel <= w_new_sel;
          if (r_mode_q) begin
            r_per    <= w_per_load;
            r_mode_q <= mode_i;
          end
        end else begin
          if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
          if (w_ref_rise) r_per <= r_per - WIN_W'(1);
        end
      end
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = r_done;
  assign cal_val_o = r_cal_val;
  assign ovf_o     = r_ovf;
  assign div_sel_o = r_div_sel;

endmodule

// File: doc/ring_osc_cal_ctrl.md
# ring_osc_cal_ctrl

Parametrised ring-oscillator calibration controller; successor to the fixed two-period calibration counter. Runs entirely in the ring-oscillator clock domain and treats the 32.768 kHz reference as a sampled data input. Measures ring-oscillator cycles over a programmable number of reference periods, in one-shot or continuous mode. Returns the raw count and a threshold-derived divider SEL for the ASSP clock divider.

## Interface
Parameters:
- CNT_W, 16, width of cycle counter and cal_val_o
- WIN_W, 4, width of win_len_i (window = 1..2^WIN_W-1 reference periods)
- DIV4_THR, 32, minimum count for SEL 3'b011
- DIV5_THR, 395, minimum count for SEL 3'b100
- DIV6_THR, 494, minimum count for SEL 3'b101
- DIV7_THR, 595, minimum count for SEL 3'b110
- DIV8_THR, 693, minimum count for SEL 3'b111

Ports:
- clk_ringosc_i  in  1  ring-oscillator/2 clock; the only clock
- reset_i  in  1  reset, asynchronous, active-high
- clk_32khz_i  in  1  32.768 kHz reference, asynchronous, sampled as data
- enable_i  in  1  block enable; low aborts and idles
- start_i  in  1  one-shot trigger, single-cycle pulse
- mode_i  in  1  0 = one-shot, 1 = continuous
- win_len_i  in  WIN_W  reference periods per window; 0 treated as 1
- busy_o  out  1  measurement armed or counting
- done_o  out  1  one-cycle pulse when results update
- cal_val_o  out  CNT_W  last measured cycle count
- ovf_o  out  1  last measurement saturated
- div_sel_o  out  3  divider SEL for ASSP

## Operation
- Reference handling: 2-FF synchronizer plus a third register. ref_rise = r2 & ~r3.
- FSM states: IDLE, ARM, COUNT.
- IDLE -> ARM when enable_i & (start_i | mode_i).
- ARM -> COUNT on ref_rise.
  - Clears cnt to 0 and loads per = max(win_len_i, 1).
  - Samples mode_i into mode_q.
- COUNT, every cycle: cnt increments, saturating at all-ones.
- COUNT on ref_rise with per > 1: per decrements.
- COUNT on ref_rise with per == 1 (window end):
  - cal_val_o <= sat(cnt+1), so the value equals the cycle distance between the opening and closing ref_rise.
  - ovf_o <= saturated; done_o pulses.
  - If mode_q = 1: stay in COUNT, clear cnt, reload per and mode_q from the inputs. The closing edge opens the next window with no gap.
  - If mode_q = 0: go to IDLE.
- SEL mapping of the measured value v, highest threshold first:
  - v >= DIV8_THR -> 111
  - v >= DIV7_THR -> 110
  - v >= DIV6_THR -> 101
  - v >= DIV5_THR -> 100
  - v >= DIV4_THR -> 011
  - v < DIV4_THR (reference dead or oscillator stopped) -> 111
  - ovf -> 111
- enable_i low in any state: FSM goes to IDLE next edge; cnt and per clear. cal_val_o, ovf_o and div_sel_o hold their last values; no done_o.
- start_i while busy_o is high is ignored. mode_i changes take effect only at ARM entry or at a window end.
- Comparisons are unsigned, at CNT_W bits. Thresholds are truncated to CNT_W.

## Timing
- Reset values:
  - state IDLE
  - busy_o 0, done_o 0
  - cal_val_o 0, ovf_o 0
  - div_sel_o 3'b111
  - synchronizer registers 0
- Reference edge to ref_rise: 2–3 clk cycles of synchronizer latency. This latency is constant, so it cancels in the count.
- start_i sampled high at edge e: busy_o high after e.
- Window-end ref_rise at edge k: cal_val_o, ovf_o, div_sel_o and done_o all update at k. done_o is high for exactly one cycle.
- busy_o is high in ARM and COUNT. In continuous mode it never drops between windows.
- Requirement: clk_ringosc_i frequency must be at least 4× the reference frequency. Below that, edges may be missed; this is not checked.
- reset_i mid-window: immediate return to reset values.

## Configuration
- RING_OSC_CAL_HYST_EN defined:
  - div_sel_o changes only when two consecutive completed windows produce the same new SEL.
  - A pending SEL register (reset 3'b111) holds the candidate.
  - cal_val_o and done_o still update every window.
  - The first window after reset can never change div_sel_o.
- Not defined: div_sel_o updates on every completed window.

## Structure
- Package ring_osc_cal_pkg holds:
  - FSM state enum
  - SEL constants DIV4_SEL..DIV8_SEL (3'b011..3'b111)
  - SEL_SAFE = 3'b111
  - default threshold values
- Sub-module ring_osc_ref_sync: synchronizer plus rising-edge detector, with output ref_rise_o. Reset clears all three flops.

## Test plan
- Reference period 500 clk, win_len_i=1, one-shot start:
  - cal_val_o = 500, div_sel_o = 101, done_o single pulse, busy_o low after.
- Reference period 400 clk, win_len_i=2, thresholds doubled:
  - cal_val_o = 800, div_sel_o = 100.
- Continuous mode, reference period 300 clk, win_len_i=3:
  - done_o every 900 clk, cal_val_o = 900 each time, no lost cycles.
  - Change win_len_i mid-window: new length applies only to the next window.
- Reference held low, or CNT_W=8 with reference period 500:
  - Dead reference: busy_o stays high until enable_i is dropped; outputs hold.
  - CNT_W=8: cal_val_o = 255, ovf_o = 1, div_sel_o = 111.
- enable_i dropped mid-COUNT, then reset_i pulsed mid-ARM:
  - Enable drop: busy_o low next cycle; prior results held; no done_o.
  - Reset pulse: all outputs at reset values.
- With RING_OSC_CAL_HYST_EN, continuous windows measuring 500, 600, 600:
  - div_sel_o goes 111, 111, 110.
  - Without the macro: 101, 110, 110.
